quickq_ctrl: RTL

- Sequencer for the QuickQ BRAM-backed priority queue. Accepts push/pop commands and walks the single-port BRAM one address per step.
- Applies the queue compare/swap rule (carry > stored, or stored slot is empty, means swap) on push. On pop, shifts entries toward address 0.
- Keeps the queue sorted descending from address 0. Empty slots hold EMPTY_KEY.
- Sits between the host command interface and the queue BRAM, and owns the occupancy count and the full/empty flags.

---
 rtl/quickq_if.sv | 15 +
 rtl/quickq_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/quickq_if.sv
// Host command/response channel for the QuickQ sequencer.
interface quickq_if #(parameter int DW = 32);
  logic          in_valid;
  logic          in_op;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          err;

  modport master (output in_valid, in_op, in_data,
                  input  in_ready, out_valid, out_data, err);
  modport slave  (input  in_valid, in_op, in_data,
                  output in_ready, out_valid, out_data, err);
endinterface

// File: rtl/quickq_ctrl.sv
// QuickQ sequencer: walks a single-port BRAM to keep a descending-sorted
// priority queue, one address per step; owns occupancy and full/empty.
module quickq_ctrl #(
  parameter int            DEPTH     = 16,
  parameter int            DW        = 32,
  parameter logic [DW-1:0] EMPTY_KEY = {DW{1'b1}},
  localparam int           AW        = $clog2(DEPTH),
  localparam int           CW        = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  quickq_if.slave       host,
  output logic [AW-1:0] bram_addr,
  output logic          bram_we,
  output logic [DW-1:0] bram_wdata,
  input  logic [DW-1:0] bram_rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          busy
);

  typedef enum logic [3:0] {
    INIT, IDLE, P_RD, P_CMP, Q_RD0, Q_CAP, S_RD, S_WR, Q_CLR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] carry_q, carry_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;
  logic          init_go_q, init_go_d;

  logic          in_ready, accept, swap;
  logic [DW-1:0] new_carry;

  assign in_ready       = (state_q == IDLE);
  assign accept         = host.in_valid && in_ready;
  assign full           = (count_q == CW'(DEPTH));
  assign empty          = (count_q == '0);
  assign count          = count_q;
  assign busy           = ~in_ready;
  assign host.in_ready  = in_ready;
  assign host.out_valid = out_valid_q;
  assign host.out_data  = out_data_q;
  assign host.err       = err_q;

  // Empty slots always swap so the carried key drops into the first hole.
  assign swap      = (carry_q > bram_rdata) || (bram_rdata == EMPTY_KEY);
  assign new_carry = swap ? bram_rdata : carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      idx_q       <= '0;
      count_q     <= '0;
      carry_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      init_go_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      init_go_q   <= init_go_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    carry_d     = carry_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    init_go_d   = 1'b1;
    case (state_q)
      // The first cycle out of reset is idle so BRAM outputs start at zero.
      INIT: if (init_go_q) begin
        if (idx_q == AW'(DEPTH-1)) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      IDLE: if (accept) begin
        if (!host.in_op) begin
          if (full || host.in_data == EMPTY_KEY) begin
            err_d = 1'b1;
          end else begin
            idx_d   = '0;
            carry_d = host.in_data;
            state_d = P_RD;
          end
        end else if (empty) begin
          err_d = 1'b1;
        end else begin
          idx_d   = '0;
          state_d = Q_RD0;
        end
      end
      P_RD:  state_d = P_CMP;
      P_CMP: begin
        carry_d = new_carry;
        if (new_carry == EMPTY_KEY) begin
          count_d = count_q + 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = P_RD;
        end
      end
      Q_RD0: state_d = Q_CAP;
      Q_CAP: begin
        out_data_d  = bram_rdata;
        out_valid_d = 1'b1;
        idx_d       = '0;
        state_d     = (count_q == CW'(1)) ? Q_CLR : S_RD;
      end
      S_RD:  state_d = S_WR;
      S_WR: begin
        if (CW'(idx_q) + CW'(1) == count_q - CW'(1)) begin
          idx_d   = AW'(count_q - CW'(1));
          state_d = Q_CLR;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RD;
        end
      end
      Q_CLR: begin
        count_d = count_q - 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // Write data in P_CMP/S_WR depends on this cycle's read data, so the BRAM
  // port is driven combinationally from state.
  always_comb begin
    bram_addr  = '0;
    bram_we    = 1'b0;
    bram_wdata = '0;
    case (state_q)
      INIT: if (init_go_q) begin
        bram_we    = 1'b1;
        bram_addr  = idx_q;
        bram_wdata = EMPTY_KEY;
      end
      P_RD:  bram_addr = idx_q;
      P_CMP: begin
        bram_we    = 1'b1;
        bram_addr  = idx_q;
        bram_wdata = swap ? carry_q : bram_rdata;
      end
      S_RD:  bram_addr = idx_q + 1'b1;
      S_WR: begin
        bram_we    = 1'b1;
        bram_addr  = idx_q;
        bram_wdata = bram_rdata;
      end
      Q_CLR: begin
        bram_we    = 1'b1;
        bram_addr  = idx_q;
        bram_wdata = EMPTY_KEY;
      end
      default: ;
    endcase
  end

endmodule
